// File: rtl/stream_pkg.sv
// Shared definitions for the byte-stream generator and sink:
// FSM encodings and default geometry.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/stream_sink_fifo.sv
// Circular byte buffer for the stream sink: write/read pointers, occupancy,
// registered empty/full flags and a registered read port.
module stream_sink_fifo
    import stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] rptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              empty_reg;
    logic              full_reg;
    logic [DATA_W-1:0] dout_reg;
    logic              dout_valid_reg;
    logic              do_rd;

    // A pop against an empty buffer is simply ignored.
    assign do_rd = rd && !empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({wr, do_rd})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            empty_reg      <= 1'b1;
            full_reg       <= 1'b0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            if (wr) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (do_rd) begin
                rptr_reg <= rptr_reg + 1'b1;
                dout_reg <= mem[rptr_reg];
            end
            dout_valid_reg <= do_rd;
            count_reg      <= count_next;
            empty_reg      <= (count_next == '0);
            full_reg       <= (count_next == DEPTH_C);
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign count      = count_reg;
    assign empty      = empty_reg;
    assign full       = full_reg;

endmodule

// File: rtl/stream_sink.sv
// Receiving end of the 8-bit byte stream: frames packets on tlast, buffers
// beats and lets the local consumer drain them with pop.
module stream_sink
    import stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tdata,
    input  logic              tvalid,
    input  logic              tlast,
    output logic              tready,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADDR_W:0]   buff_count,
    output logic              empty,
    output logic              full,
    output logic              pkt_done,
    output logic [ADDR_W:0]   pkt_len
);

    localparam logic [ADDR_W:0] CNT_MAX = '1;

    state_t          state_reg;
    state_t          state_next;
    logic [ADDR_W:0] beat_cnt_reg;
    logic [ADDR_W:0] beat_inc;
    logic [ADDR_W:0] pkt_len_reg;
    logic            pkt_done_reg;
    logic            xfer;

    // Only registered state and the reset input feed tready; tvalid/pop never do.
    assign tready   = !rst && (state_reg != HOLD) && !full;
    assign xfer     = tvalid && tready;
    assign beat_inc = (beat_cnt_reg == CNT_MAX) ? beat_cnt_reg : beat_cnt_reg + 1'b1;

    stream_sink_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr         (xfer),
        .wdata      (tdata),
        .rd         (pop),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (buff_count),
        .empty      (empty),
        .full       (full)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    state_next = tlast ? HOLD : RECV;
                end
            end
            RECV: begin
                if (xfer && tlast) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            pkt_len_reg  <= '0;
            pkt_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pkt_done_reg <= xfer && tlast;
            if (xfer) begin
                if (tlast) begin
                    pkt_len_reg  <= beat_inc;
                    beat_cnt_reg <= '0;
                end else begin
                    beat_cnt_reg <= beat_inc;
                end
            end
        end
    end

    assign pkt_done = pkt_done_reg;
    assign pkt_len  = pkt_len_reg;

endmodule

// File: tb/tb_stream_sink.sv
// Scoreboard bench for stream_sink: sent bytes and packet lengths are queued
// as they are issued and checked by a monitor as the sink presents them.
module tb_stream_sink;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;
    logic       pop;
    logic [7:0] dout;
    logic       dout_valid;
    logic [4:0] buff_count;
    logic       empty;
    logic       full;
    logic       pkt_done;
    logic [4:0] pkt_len;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [7:0] exp_q [$];
    logic [4:0] len_q [$];

    always #5 clk = ~clk;

    stream_sink dut (
        .clk        (clk),
        .rst        (rst),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tlast      (tlast),
        .tready     (tready),
        .pop        (pop),
        .dout       (dout),
        .dout_valid (dout_valid),
        .buff_count (buff_count),
        .empty      (empty),
        .full       (full),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: compares every presented byte and packet length against the queues.
    always @(negedge clk) begin
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                check("dout_unexpected", 1, 0);
            end else begin
                check("dout", int'(dout), int'(exp_q.pop_front()));
            end
        end
        if (pkt_done) begin
            done_cnt++;
            if (len_q.size() == 0) begin
                check("pkt_done_unexpected", 1, 0);
            end else begin
                check("pkt_len", int'(pkt_len), int'(len_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        while (!tready && n < 200) begin
            step();
            n++;
        end
        if (!tready) begin
            check("send_timeout", 1, 0);
        end else begin
            exp_q.push_back(d);
            step();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic pop_one();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!empty && n < 200) begin
            pop_one();
            n++;
        end
        check("drain_empty", int'(empty), 1);
        step();
    endtask

    initial begin
        logic [7:0] held;
        int d0;
        rst = 1'b1; tdata = '0; tvalid = 1'b0; tlast = 1'b0; pop = 1'b0;

        // 1: reset state
        step();
        step();
        check("rst_tready", int'(tready), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_count", int'(buff_count), 0);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_pkt_len", int'(pkt_len), 0);
        rst = 1'b0;
        #1;
        check("tready_after_rst", int'(tready), 1);

        // 2: four-beat packet, then drain
        len_q.push_back(5'd4);
        for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), i == 3);
        check("p2_count", int'(buff_count), 4);
        check("p2_tready_hold", int'(tready), 0);
        step();
        check("p2_done_once", done_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            pop_one();
            check("p2_dout_valid_next", int'(dout_valid), 1);
        end
        check("p2_count0", int'(buff_count), 0);
        check("p2_tready_still0", int'(tready), 0);
        step();
        check("p2_tready_reopen", int'(tready), 1);

        // 3: 17-beat packet against a 16-entry buffer
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0);
        check("p3_full", int'(full), 1);
        check("p3_count16", int'(buff_count), 16);
        check("p3_tready_bp", int'(tready), 0);
        tvalid = 1'b1; tdata = 8'h20; tlast = 1'b1;
        pop_one();
        check("p3_tready_after_pop", int'(tready), 1);
        exp_q.push_back(8'h20);
        len_q.push_back(5'd17);
        step();
        tvalid = 1'b0; tlast = 1'b0;
        check("p3_count_after_last", int'(buff_count), 16);
        drain();

        // Pre-advance pointers: 21 beats so far -> 9 more brings them to 14
        len_q.push_back(5'd9);
        for (int i = 0; i < 9; i++) send(8'h40 + 8'(i), i == 8);
        drain();

        // 4: steady occupancy of 5 across the pointer wrap
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 1'b0);
        check("p4_count5", int'(buff_count), 5);
        for (int i = 0; i < 8; i++) begin
            tvalid = 1'b1; tdata = 8'h60 + 8'(i); pop = 1'b1;
            check("p4_tready", int'(tready), 1);
            exp_q.push_back(tdata);
            step();
            check("p4_count_hold", int'(buff_count), 5);
        end
        tvalid = 1'b0; pop = 1'b0;
        len_q.push_back(5'd14);
        send(8'h70, 1'b1);
        drain();

        // 5: pop while empty is ignored
        step();
        held = dout;
        pop_one();
        check("p5_dout_valid", int'(dout_valid), 0);
        check("p5_count", int'(buff_count), 0);
        check("p5_dout_held", int'(dout), int'(held));

        // 6: reset mid-packet, then a fresh 2-beat packet
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) send(8'h81 + 8'(i), 1'b0);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
        step();
        check("p6_count_cleared", int'(buff_count), 0);
        check("p6_empty", int'(empty), 1);
        check("p6_no_done", done_cnt, d0);
        len_q.push_back(5'd2);
        send(8'h55, 1'b0);
        send(8'h66, 1'b1);
        drain();

        repeat (3) step();
        check("left_bytes", exp_q.size(), 0);
        check("left_lens", len_q.size(), 0);
        check("total_pkts", done_cnt, 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
